// File: rtl/affine_sched_rx.sv
// affine_sched_rx: affine-scheduled receive port that writes producer data into a buffer at scheduled cycles
module affine_sched_rx (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [1:0]       dimensionality,
  input  logic [1:0][15:0] ranges,
  input  logic [15:0]      time_start,
  input  logic [1:0][15:0] time_strides,
  input  logic [15:0]      addr_start,
  input  logic [1:0][15:0] addr_strides,
  input  logic             valid_in,
  input  logic [15:0]      data_in,
  output logic             wen,
  output logic [15:0]      waddr,
  output logic [15:0]      wdata,
  output logic             done,
  output logic             err_unsched,
  output logic             err_missed,
  output logic [15:0]      iter_count
);
  logic [15:0] cycle_time, i_in, i_out, exp_time, exp_addr, base_time, base_addr;
  logic [15:0] last_in, last_out;
  logic        dim2, slot;
  assign dim2     = dimensionality >= 2'd2;
  assign last_in  = (ranges[0] == 16'd0) ? 16'd0 : ranges[0] - 16'd1;
  assign last_out = (ranges[1] == 16'd0) ? 16'd0 : ranges[1] - 16'd1;
  assign slot     = clk_en && !done && (cycle_time == exp_time);
  // exp_* walk the inner stride; base_* hold the start of the current outer row
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_time  <= '0;
      i_in        <= '0;
      i_out       <= '0;
      exp_time    <= time_start;
      exp_addr    <= addr_start;
      base_time   <= time_start;
      base_addr   <= addr_start;
      wen         <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      done        <= 1'b0;
      err_unsched <= 1'b0;
      err_missed  <= 1'b0;
      iter_count  <= '0;
    end else begin
      wen <= slot && valid_in;
      if (slot && valid_in) begin
        waddr <= exp_addr;
        wdata <= data_in;
      end
      if (clk_en) begin
        cycle_time <= cycle_time + 16'd1;
        if (valid_in && !slot) err_unsched <= 1'b1;
      end
      if (slot) begin
        iter_count <= iter_count + 16'd1;
        if (!valid_in) err_missed <= 1'b1;
        if (i_in < last_in) begin
          i_in     <= i_in + 16'd1;
          exp_time <= exp_time + time_strides[0];
          exp_addr <= exp_addr + addr_strides[0];
        end else if (dim2 && i_out < last_out) begin
          i_in      <= '0;
          i_out     <= i_out + 16'd1;
          base_time <= base_time + time_strides[1];
          base_addr <= base_addr + addr_strides[1];
          exp_time  <= base_time + time_strides[1];
          exp_addr  <= base_addr + addr_strides[1];
        end else begin
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_affine_sched_rx.sv
// tb_affine_sched_rx: randomized and directed checks against an iteration-list reference model
module tb_affine_sched_rx;
  logic             clk = 1'b0, rst = 1'b1, clk_en = 1'b0, valid_in = 1'b0;
  logic [1:0]       dimensionality = 2'd2;
  logic [1:0][15:0] ranges = '0, time_strides = '0, addr_strides = '0;
  logic [15:0]      time_start = '0, addr_start = '0, data_in = '0;
  logic             wen, done, err_unsched, err_missed;
  logic [15:0]      waddr, wdata, iter_count;
  logic [51:0]      obs;
  int               errors = 0, checks = 0;
  int               m_k;
  logic [15:0]      m_ct, m_waddr, m_wdata, m_cnt;
  logic             m_wen, m_done, m_eu, m_em;
  logic [15:0]      wq[$];

  affine_sched_rx dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dimensionality(dimensionality),
    .ranges(ranges), .time_start(time_start), .time_strides(time_strides),
    .addr_start(addr_start), .addr_strides(addr_strides), .valid_in(valid_in),
    .data_in(data_in), .wen(wen), .waddr(waddr), .wdata(wdata), .done(done),
    .err_unsched(err_unsched), .err_missed(err_missed), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  assign obs = {wen, waddr, wdata, done, err_unsched, err_missed, iter_count};

  function automatic int eff(logic [15:0] r);
    return (r == 16'd0) ? 1 : int'(r);
  endfunction

  function automatic int total();
    return (dimensionality >= 2'd2) ? eff(ranges[0]) * eff(ranges[1]) : eff(ranges[0]);
  endfunction

  // iteration k = outer*range_in + inner, scheduled by the plain affine formula
  function automatic logic [15:0] t_of(int k);
    logic [31:0] s;
    s = 32'(time_start) + 32'(k / eff(ranges[0])) * 32'(time_strides[1])
      + 32'(k % eff(ranges[0])) * 32'(time_strides[0]);
    return s[15:0];
  endfunction

  function automatic logic [15:0] a_of(int k);
    logic [31:0] s;
    s = 32'(addr_start) + 32'(k / eff(ranges[0])) * 32'(addr_strides[1])
      + 32'(k % eff(ranges[0])) * 32'(addr_strides[0]);
    return s[15:0];
  endfunction

  function automatic logic [51:0] exp_vec();
    return {m_wen, m_waddr, m_wdata, m_done, m_eu, m_em, m_cnt};
  endfunction

  function automatic bit is_slot(bit en);
    return en && !m_done && (m_ct == t_of(m_k));
  endfunction

  function automatic bit q_is(input logic [15:0] e[$]);
    bit ok = (wq.size() == e.size());
    for (int i = 0; ok && i < e.size(); i++) ok = (wq[i] == e[i]);
    return ok;
  endfunction

  task automatic step(input bit r, input bit en, input bit v, input logic [15:0] d);
    bit sl;
    rst = r; clk_en = en; valid_in = v; data_in = d;
    if (r) begin
      m_ct = 0; m_k = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
      m_done = 0; m_eu = 0; m_em = 0; m_cnt = 0;
    end else begin
      sl = is_slot(en);
      m_wen = sl && v;
      if (sl && v) begin m_waddr = a_of(m_k); m_wdata = d; end
      if (en && v && !sl) m_eu = 1;
      if (sl && !v) m_em = 1;
      if (sl) begin m_k++; m_cnt++; if (m_k == total()) m_done = 1; end
      if (en) m_ct++;
    end
    @(posedge clk); #1;
  endtask

  task automatic cfg_basic();
    dimensionality = 2'd2;
    ranges[1] = 16'd2; ranges[0] = 16'd3;
    time_start = 16'd10; time_strides[1] = 16'd11; time_strides[0] = 16'd1;
    addr_start = 16'd0; addr_strides[1] = 16'd3; addr_strides[0] = 16'd1;
  endtask

  function automatic bit pulse(int c);
    return c == 10 || c == 11 || c == 12 || c == 21 || c == 22 || c == 23;
  endfunction

  task automatic test_reset();
    cfg_basic();
    step(1, 1, 1, 16'hbeef);
    checks++;
    if ({wen, waddr, wdata, done, err_unsched, err_missed, iter_count} !== 52'd0) begin
      errors++; $display("FAIL reset got=%h exp=0", obs);
    end
    step(1, 1, 1, 16'h1234);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_prio got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic run_pattern(input string nm, input bit miss, input bit extra);
    bit v;
    step(1, 0, 0, 16'd0);
    wq.delete();
    for (int c = 0; c < 32; c++) begin
      v = (pulse(c) && !(miss && c == 21)) || (extra && (c == 15 || c == 30));
      step(0, 1, v, 16'($urandom));
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c + 1, obs, exp_vec()); end
      if (wen) wq.push_back(waddr);
      if (c == 22 || c == 23) begin
        checks++;
        if (done !== (c == 23)) begin errors++; $display("FAIL %s_done cyc=%0d got=%b exp=%b", nm, c + 1, done, c == 23); end
      end
    end
  endtask

  task automatic test_basic();
    cfg_basic();
    run_pattern("basic", 0, 0);
    checks++;
    if (!q_is('{0, 1, 2, 3, 4, 5}) || iter_count !== 16'd6 || err_missed || err_unsched) begin
      errors++; $display("FAIL basic_summary got=n%0d/ic%0d/e%b%b exp=n6/ic6/e00", wq.size(), iter_count, err_missed, err_unsched);
    end
  endtask

  task automatic test_missed();
    cfg_basic();
    run_pattern("missed", 1, 0);
    checks++;
    if (!q_is('{0, 1, 2, 4, 5}) || err_missed !== 1'b1 || err_unsched !== 1'b0) begin
      errors++; $display("FAIL missed_summary got=n%0d/e%b%b exp=n5/e10", wq.size(), err_missed, err_unsched);
    end
  endtask

  task automatic test_unsched();
    cfg_basic();
    run_pattern("unsched", 0, 1);
    checks++;
    if (!q_is('{0, 1, 2, 3, 4, 5}) || err_unsched !== 1'b1 || err_missed !== 1'b0) begin
      errors++; $display("FAIL unsched_summary got=n%0d/e%b%b exp=n6/e01", wq.size(), err_missed, err_unsched);
    end
  endtask

  task automatic test_dim1();
    dimensionality = 2'd1;
    ranges[1] = 16'd7; ranges[0] = 16'd4;
    time_start = 16'd0; time_strides[1] = 16'($urandom); time_strides[0] = 16'd2;
    addr_start = 16'd0; addr_strides[1] = 16'($urandom); addr_strides[0] = 16'd5;
    step(1, 0, 0, 16'd0);
    wq.delete();
    for (int c = 0; c < 12; c++) begin
      step(0, 1, c == 0 || c == 2 || c == 4 || c == 6, 16'($urandom));
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL dim1 cyc=%0d got=%h exp=%h", c + 1, obs, exp_vec()); end
      if (wen) wq.push_back(waddr);
      if (c == 5 || c == 6) begin
        checks++;
        if (done !== (c == 6)) begin errors++; $display("FAIL dim1_done cyc=%0d got=%b exp=%b", c + 1, done, c == 6); end
      end
    end
    checks++;
    if (!q_is('{0, 5, 10, 15}) || err_missed || err_unsched) begin
      errors++; $display("FAIL dim1_summary got=n%0d/e%b%b exp=n4/e00", wq.size(), err_missed, err_unsched);
    end
  endtask

  task automatic test_mid_reset();
    cfg_basic();
    step(1, 0, 0, 16'd0);
    for (int c = 0; c < 12; c++) step(0, 1, pulse(c), 16'($urandom));
    step(1, 1, 1, 16'hdead);
    checks++;
    if (wen !== 1'b0 || iter_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset_drop got=w%b/ic%0d exp=w0/ic0", wen, iter_count);
    end
    wq.delete();
    for (int c = 0; c < 30; c++) begin
      step(0, 1, pulse(c), 16'($urandom));
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c + 1, obs, exp_vec()); end
      if (wen) wq.push_back(waddr);
    end
    checks++;
    if (!q_is('{0, 1, 2, 3, 4, 5}) || iter_count !== 16'd6) begin
      errors++; $display("FAIL mid_reset_replay got=n%0d/ic%0d exp=n6/ic6", wq.size(), iter_count);
    end
  endtask

  task automatic test_clk_en();
    bit en, v;
    cfg_basic();
    step(1, 0, 0, 16'd0);
    wq.delete();
    for (int c = 0; c < 34; c++) begin
      en = !(c >= 11 && c <= 14);
      v = en ? pulse(int'(m_ct)) : (c == 12);
      step(0, en, v, 16'($urandom));
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL clk_en cyc=%0d got=%h exp=%h", c + 1, obs, exp_vec()); end
      if (wen) wq.push_back(waddr);
      if (c == 15) begin
        checks++;
        if (wen !== 1'b1 || waddr !== 16'd1) begin errors++; $display("FAIL clk_en_slot got=w%b/a%0d exp=w1/a1", wen, waddr); end
      end
    end
    checks++;
    if (!q_is('{0, 1, 2, 3, 4, 5}) || err_missed || err_unsched || !done) begin
      errors++; $display("FAIL clk_en_summary got=n%0d/e%b%b/d%b exp=n6/e00/d1", wq.size(), err_missed, err_unsched, done);
    end
  endtask

  task automatic test_random();
    bit en, v;
    int tail, ri;
    for (int n = 0; n < 40; n++) begin
      dimensionality = 2'($urandom);
      ranges[0] = 16'($urandom_range(0, 4));
      ranges[1] = 16'($urandom_range(0, 3));
      ri = eff(ranges[0]);
      time_strides[0] = 16'($urandom_range(1, 3));
      time_strides[1] = 16'((ri - 1) * int'(time_strides[0]) + 1 + int'($urandom_range(0, 3)));
      time_start = 16'($urandom_range(0, 19));
      addr_start = 16'($urandom); addr_strides[0] = 16'($urandom); addr_strides[1] = 16'($urandom);
      step(1, 0, 0, 16'd0);
      tail = 0;
      for (int c = 0; c < 300 && tail < 4; c++) begin
        en = ($urandom_range(0, 5) != 0);
        v = is_slot(en) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
        step(0, en, v, 16'($urandom));
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL random cfg=%0d cyc=%0d got=%h exp=%h", n, c + 1, obs, exp_vec()); end
        if (m_done) tail++;
      end
      checks++;
      if (tail < 4) begin errors++; $display("FAIL random_timeout cfg=%0d got=done%b exp=done1", n, done); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_missed();
    test_unsched();
    test_dim1();
    test_mid_reset();
    test_clk_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
